// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a 32-bit XNOR LFSR stream (taps 32,22,2,1) and flags mispredicted words.
module lfsr_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_in,
    input  logic             data_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic             lockup
);
    typedef enum logic [1:0] {SEED, SYNC, LOCKED} state_t;
    localparam logic [3:0] LC = LOCK_COUNT[3:0];
    localparam logic [3:0] UC = UNLOCK_COUNT[3:0];
    state_t state, state_n;
    logic [31:0] pred, pred_n;
    logic [3:0] match_cnt, match_n, miss_cnt, miss_n;
    logic err_n, lockup_n, ones, hit;
    function automatic logic [31:0] nxt(input logic [31:0] w);
        return {w[30:0], ~(w[31] ^ w[21] ^ w[1] ^ w[0])};
    endfunction
    assign ones = data_in == 32'hFFFF_FFFF;
    assign hit  = data_in == pred;
    always_comb begin
        state_n  = state;
        pred_n   = pred;
        match_n  = match_cnt;
        miss_n   = miss_cnt;
        err_n    = 1'b0;
        lockup_n = 1'b0;
        if (data_valid) begin
            case (state)
                SEED: begin
                    lockup_n = ones;
                    if (!ones) begin
                        pred_n  = nxt(data_in);
                        match_n = 4'd0;
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    pred_n = nxt(data_in);
                    if (ones) begin
                        lockup_n = 1'b1;
                        state_n  = SEED;
                    end else if (hit) begin
                        match_n = match_cnt + 4'd1;
                        if (match_n == LC) begin
                            state_n = LOCKED;
                            miss_n  = 4'd0;
                        end
                    end else begin
                        match_n = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so isolated bit errors never desync.
                    pred_n = nxt(pred);
                    if (hit) begin
                        miss_n = 4'd0;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss_cnt + 4'd1;
                        if (miss_n == UC) begin
                            state_n = SYNC;
                            pred_n  = nxt(data_in);
                            match_n = 4'd0;
                        end
                    end
                end
                default: state_n = SEED;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEED;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            lockup    <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            locked    <= state_n == LOCKED;
            error     <= err_n;
            lockup    <= lockup_n;
            if (clear_cnt) err_count <= '0;
            else if (err_n && err_count != '1) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side partner of the 32-bit XNOR LFSR random source (taps 32, 22, 2, 1).
- Takes a stream of 32-bit words that should come from that generator, synchronises to it, then predicts each next word and flags deviations.
- Used to verify RNG outputs feeding p-bit arrays, in hardware and in loopback tests.
- Supplies lock status, a per-sample error pulse and a saturating error count.

Parameters:
- LOCK_COUNT, 4, consecutive correct predictions needed to enter LOCKED (1..15).
- UNLOCK_COUNT, 3, consecutive mispredictions in LOCKED before falling back to SYNC (1..15).
- ERR_W, 16, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  32  observed LFSR word.
- data_valid  input  1  data_in is sampled this cycle.
- clear_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- error  output  1  one-cycle pulse for a misprediction while LOCKED.
- err_count  output  ERR_W  saturating misprediction count.
- lockup  output  1  one-cycle pulse when an all-ones word is rejected as a seed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Next-state function, with w[31:0]:
  - next(w) = {w[30:0], fb}
  - fb = ~(w[31] ^ w[21] ^ w[1] ^ w[0])
  - This is bit-exact with the generator.
- All-ones is the generator's lock-up state; it is never a valid seed.
- Internal state: FSM state, pred[31:0], match_cnt[3:0], miss_cnt[3:0].
- Reset values:
  - state = SEED; pred, match_cnt, miss_cnt = 0.
  - locked = 0, error = 0, err_count = 0, lockup = 0.
- data_valid = 0: all state holds; error and lockup drop to 0.
- Every output is registered. Any response to a sample taken in cycle N is visible in cycle N+1.
- SEED, on a valid sample:
  - data_in == 32'hFFFFFFFF: pulse lockup, stay in SEED.
  - Otherwise: pred = next(data_in), match_cnt = 0, go to SYNC.
- SYNC, on a valid sample:
  - data_in == 32'hFFFFFFFF: pulse lockup, go to SEED.
  - data_in == pred: match_cnt + 1, pred = next(data_in). If the new match_cnt == LOCK_COUNT, go to LOCKED and clear miss_cnt.
  - Mismatch: reseed. pred = next(data_in), match_cnt = 0.
  - No error pulses and no counting while in SYNC.
- LOCKED, on a valid sample:
  - Match: miss_cnt = 0.
  - Mismatch: pulse error, saturating increment of err_count, miss_cnt + 1.
  - In both cases pred = next(pred). The checker flywheels, so isolated bit errors do not cause a desync.
  - If a mismatch makes miss_cnt == UNLOCK_COUNT: go to SYNC with pred = next(data_in) and match_cnt = 0; locked falls the next cycle.
- err_count:
  - Saturates at 2^ERR_W-1.
  - clear_cnt sets it to 0 and wins over a simultaneous increment; the error pulse is still emitted.
  - clear_cnt does not affect the FSM.
- Reset asserted mid-stream returns to SEED regardless of state and clears err_count. The first valid sample after reset reseeds.
- data_valid gaps of any length do not affect prediction; only valid samples advance pred.

Test Plan:
- Lock acquisition:
  - Stimulus: reset, then valid words 0x00000001, 0x00000002, 0x00000004, 0x00000009, 0x00000012, back-to-back.
  - Response: locked = 1 the cycle after 0x12; error never set; err_count = 0.
- Single error while locked:
  - Stimulus: after the lock above, feed 0x00000025 in place of 0x00000024, then 0x00000049.
  - Response: one error pulse; err_count = 1; locked stays 1; 0x49 is a match.
- Loss of lock:
  - Stimulus: while locked, feed 3 consecutive wrong words (e.g. 0xDEADBEEF).
  - Response: 3 error pulses; err_count + 3; locked = 0 after the third; a correct continuation from the third word relocks after 4 matches.
- Lock-up seed:
  - Stimulus: reset, then 0xFFFFFFFF.
  - Response: lockup pulse; stays in SEED (locked = 0); a following 0x00000001 seeds normally.
- Gaps and clear:
  - Stimulus: the lock sequence with data_valid low for 1–5 random cycles between words.
  - Response: same lock timing relative to valid samples.
  - Stimulus: assert clear_cnt in the same cycle as a mismatch sample.
  - Response: err_count = 0, error pulse still seen.
- Saturation and reset:
  - Stimulus: ERR_W = 4, force 20 mismatches (UNLOCK_COUNT = 15, relocking as needed).
  - Response: err_count holds at 15.
  - Stimulus: then assert reset for one cycle.
  - Response: err_count = 0, locked = 0.
